// File: rtl/sram_pkg.sv
// sram_pkg: shared types and helpers for the round-robin shared SRAM
package sram_pkg;
  typedef enum logic {ST_INIT, ST_RUN} sram_state_t;
  function automatic int clog2_ch(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: combinational round-robin grant starting the search at rr_ptr
module sram_rr_arbiter
  import sram_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int PW = clog2_ch(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PW-1:0]     rr_ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt,
  output logic [PW-1:0]     gnt_idx
);
  always_comb begin
    int k;
    k = 0;
    gnt = '0;
    gnt_idx = '0;
    // descending scan so the requester closest to rr_ptr is assigned last and wins
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      k = int'(rr_ptr) + i;
      k = (k >= NUM_CH) ? k - NUM_CH : k;
      if (en && req[PW'(k)]) begin
        gnt = '0;
        gnt[PW'(k)] = 1'b1;
        gnt_idx = PW'(k);
      end
    end
  end
endmodule

// File: rtl/sram_rr_shared.sv
// sram_rr_shared: single-port SRAM shared by NUM_CH clients via round-robin arbitration
module sram_rr_shared
  import sram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11,
  parameter int NUM_CH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     init_done,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        we,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  output logic [NUM_CH-1:0]        gnt,
  output logic [NUM_CH-1:0]        rvalid,
  output logic [DATA_W-1:0]        rdata
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PW = clog2_ch(NUM_CH);
  sram_state_t state, nxt;
  logic [ADDR_W-1:0] cnt;
  logic [PW-1:0] rr_ptr, gnt_idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic en, hit, we_sel;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] d;
  sram_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req(req), .rr_ptr(rr_ptr), .en(en), .gnt(gnt), .gnt_idx(gnt_idx)
  );
  always_ff @(posedge clk)
    state <= reset ? ST_INIT : nxt;
  always_comb
    nxt = (state == ST_INIT && &cnt) ? ST_RUN : state;
  always_comb begin
    en = (state == ST_RUN) && !reset;
    init_done = (state == ST_RUN);
  end
  assign hit = |gnt;
  assign we_sel = we[gnt_idx];
  assign a = addr[gnt_idx*ADDR_W +: ADDR_W];
  assign d = wdata[gnt_idx*DATA_W +: DATA_W];
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      rr_ptr <= '0;
      rvalid <= '0;
      rdata <= '0;
    end else begin
      rvalid <= '0;
      if (state == ST_INIT) cnt <= cnt + ADDR_W'(1);
      if (hit) begin
        rr_ptr <= (gnt_idx == PW'(NUM_CH - 1)) ? '0 : gnt_idx + PW'(1);
        if (!we_sel) begin
          rdata <= mem[a];
          rvalid <= gnt;
        end
      end
    end
  end
  // no reset on the array: the INIT sweep clears it one word per cycle
  always_ff @(posedge clk)
    if (!reset) begin
      if (state == ST_INIT) mem[cnt] <= '0;
      else if (hit && we_sel) mem[a] <= d;
    end
endmodule

// File: tb/tb_sram_rr_shared.sv
// tb_sram_rr_shared: directed + random checks against a behavioural shared-SRAM model
module tb_sram_rr_shared;
  localparam int DW = 8;
  localparam int AW = 11;
  localparam int NCH = 2;
  localparam int DEPTH = 2 ** AW;
  logic clk = 0;
  logic reset = 1;
  logic init_done;
  logic [NCH-1:0] req = '0, we = '0, gnt, rvalid;
  logic [NCH*AW-1:0] addr = '0;
  logic [NCH*DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  int checks = 0, errors = 0;
  int edges, ptr;
  logic run_m;
  logic [NCH-1:0] rv_m;
  logic [DW-1:0] rd_m;
  logic [DW-1:0] mem_m [DEPTH];
  sram_rr_shared #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NCH)) dut (
    .clk(clk), .reset(reset), .init_done(init_done), .req(req), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    edges = 0;
    run_m = 0;
    rv_m = '0;
    rd_m = '0;
    ptr = 0;
    foreach (mem_m[i]) mem_m[i] = '0;
  endtask
  task automatic set_ch(input int c, input logic r, input logic w, input int a, input int d);
    req[c] = r;
    we[c] = w;
    addr[c*AW +: AW] = AW'(a);
    wdata[c*DW +: DW] = DW'(d);
  endtask
  // one clock: check outputs mid-cycle against the model, then advance the model over the edge
  task automatic cyc();
    int c, ad;
    logic [NCH-1:0] eg;
    @(negedge clk);
    c = -1;
    eg = '0;
    if (!reset && run_m)
      for (int i = 0; i < NCH; i++)
        if (c < 0 && req[(ptr + i) % NCH]) c = (ptr + i) % NCH;
    if (c >= 0) eg[c] = 1'b1;
    check("gnt", gnt, eg);
    check("init_done", init_done, run_m);
    check("rvalid", rvalid, rv_m);
    check("rdata", rdata, rd_m);
    if (reset) model_reset();
    else begin
      rv_m = '0;
      if (!run_m) begin
        edges++;
        run_m = (edges == DEPTH);
      end else if (c >= 0) begin
        ad = int'(addr[c*AW +: AW]);
        if (we[c]) mem_m[ad] = wdata[c*DW +: DW];
        else begin
          rd_m = mem_m[ad];
          rv_m = NCH'(1) << c;
        end
        ptr = (c + 1) % NCH;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input int c, input int a);
    set_ch(c, 1, 0, a, 0);
    cyc();
    req = '0;
    cyc();
  endtask
  task automatic wr(input int c, input int a, input int d);
    set_ch(c, 1, 1, a, d);
    cyc();
    req = '0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 0;
    // clear sweep with idle inputs, then reads of cleared words
    repeat (DEPTH + 2) cyc();
    rd(0, 0);
    rd(0, 1023);
    rd(0, 2047);
    // write then read of the top address
    wr(0, 'h7FF, 'h5A);
    rd(0, 'h7FF);
    // align pointer to 0, then both channels read for 4 cycles
    rd(1, 5);
    set_ch(0, 1, 0, 'h7FF, 0);
    set_ch(1, 1, 0, 1, 0);
    repeat (4) cyc();
    req = '0;
    cyc();
    // ch1 write granted N, ch0 read of same address granted N+1
    rd(0, 3);
    set_ch(0, 1, 0, 'h010, 0);
    set_ch(1, 1, 1, 'h010, 'h33);
    cyc();
    req[1] = 0;
    cyc();
    req = '0;
    cyc();
    // read grant, then reset while rvalid is pending
    set_ch(0, 1, 0, 'h010, 0);
    cyc();
    reset = 1;
    cyc();
    cyc();
    reset = 0;
    // random requests during the sweep must be ignored
    for (int i = 0; i < DEPTH; i++) begin
      set_ch(0, 1'($urandom), 1'($urandom), $urandom, $urandom);
      set_ch(1, 1'($urandom), 1'($urandom), $urandom, $urandom);
      cyc();
    end
    set_ch(0, 1, 0, 'h010, 0);
    set_ch(1, 1, 0, 'h7FF, 0);
    repeat (3) cyc();
    req = '0;
    cyc();
    // randomized mix over a small address pool for collisions
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < NCH; c++) begin
        int p;
        p = $urandom_range(0, 4);
        set_ch(c, 1'($urandom), 1'($urandom),
               (p == 0) ? 0 : (p == 1) ? 'h010 : (p == 2) ? 'h7FF : (p == 3) ? 1 : $urandom,
               $urandom);
      end
      if (i == 400) reset = 1;
      cyc();
      reset = 0;
      if (i == 400) repeat (DEPTH) cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
